// File: rtl/pam4_tx_channel.sv
// PAM-4 transmit stimulus: pairs serial bits into Gray-coded symbols, maps them to signed levels,
// and applies a two-tap ISI channel. Optional feature macro: PAM4_TX_ISI_EN enables the post-cursor tap.
module pam4_tx_channel #(
    parameter int unsigned SIGNAL_RESOLUTION = 8,
    parameter int unsigned SYMBOL_SEPERATION = 56,
    parameter int unsigned H1_SHIFT          = 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         data_in,
    input  logic                         data_in_valid,
    output logic [SIGNAL_RESOLUTION-1:0] signal_out,
    output logic                         signal_out_valid
);

    localparam int unsigned R = SIGNAL_RESOLUTION;
    localparam logic signed [31:0] SEP_S = 32'(SYMBOL_SEPERATION);
    localparam logic signed [31:0] LMAX  = (32'sd1 <<< (R - 1)) - 32'sd1;
    localparam logic signed [31:0] LMIN  = -(32'sd1 <<< (R - 1));
    localparam logic [R-1:0] OUT_MAX = {1'b0, {(R-1){1'b1}}};
    localparam logic [R-1:0] OUT_MIN = {1'b1, {(R-1){1'b0}}};

    logic               r_phase;
    logic               r_b1;
    logic [1:0]         r_sym;
    logic               r_sym_valid;
    logic signed [R-1:0] r_level;
    logic               r_lvl_valid;

    logic [1:0]          w_sym;
    logic signed [31:0]  w_odd;
    logic signed [31:0]  w_lvl_wide;
    logic signed [R-1:0] w_level;
    logic [R-1:0]        w_chan;

    // Gray map of the completing pair: first bit is the MSB
    always_comb begin
        w_sym = 2'd0;
        case ({r_b1, data_in})
            2'b00:   w_sym = 2'd0;
            2'b01:   w_sym = 2'd1;
            2'b11:   w_sym = 2'd2;
            default: w_sym = 2'd3;
        endcase
    end

    // Level = (2*sym - 3) * sep / 2, computed wide then saturated
    always_comb begin
        w_odd      = $signed({29'd0, r_sym, 1'b1}) - 32'sd4;
        w_lvl_wide = (w_odd * SEP_S) / 32'sd2;
        w_level    = w_lvl_wide[R-1:0];
        if (w_lvl_wide > LMAX) begin
            w_level = LMAX[R-1:0];
        end else if (w_lvl_wide < LMIN) begin
            w_level = LMIN[R-1:0];
        end
    end

`ifdef PAM4_TX_ISI_EN
    logic signed [R-1:0] r_hist;
    logic signed [R-1:0] w_post;
    logic [R:0]          w_sum;

    // Post-cursor term from the previous level, summed one bit wider and clamped
    always_comb begin
        w_post = r_hist >>> H1_SHIFT;
        w_sum  = {r_level[R-1], r_level} + {w_post[R-1], w_post};
        w_chan = w_sum[R-1:0];
        if (w_sum[R] != w_sum[R-1]) begin
            w_chan = w_sum[R] ? OUT_MIN : OUT_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_hist <= '0;
        end else if (r_lvl_valid) begin
            r_hist <= r_level;
        end
    end
`else
    always_comb begin
        w_chan = r_level;
    end
`endif

    // Bit pairing and the three pipeline stages, each carrying its own valid
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_phase          <= 1'b0;
            r_b1             <= 1'b0;
            r_sym            <= 2'd0;
            r_sym_valid      <= 1'b0;
            r_level          <= '0;
            r_lvl_valid      <= 1'b0;
            signal_out       <= '0;
            signal_out_valid <= 1'b0;
        end else begin
            r_sym_valid <= 1'b0;
            if (data_in_valid) begin
                if (!r_phase) begin
                    r_b1    <= data_in;
                    r_phase <= 1'b1;
                end else begin
                    r_phase     <= 1'b0;
                    r_sym       <= w_sym;
                    r_sym_valid <= 1'b1;
                end
            end
            r_lvl_valid <= r_sym_valid;
            if (r_sym_valid) begin
                r_level <= w_level;
            end
            signal_out_valid <= r_lvl_valid;
            if (r_lvl_valid) begin
                signal_out <= w_chan;
            end
        end
    end

endmodule

// File: tb/tb_pam4_tx_channel.sv
// Self-checking bench for pam4_tx_channel: a pair/level/channel model with a cycle-accurate scoreboard
// plus literal expectations for each directed scenario.
module tb_pam4_tx_channel;

    localparam int unsigned R   = 8;
    localparam int          SEP = 56;
    localparam int          H1  = 1;
`ifdef PAM4_TX_ISI_EN
    localparam bit ISI = 1'b1;
`else
    localparam bit ISI = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         data_in = 1'b0;
    logic         data_in_valid = 1'b0;
    logic [R-1:0] signal_out;
    logic         signal_out_valid;

    pam4_tx_channel #(
        .SIGNAL_RESOLUTION(R),
        .SYMBOL_SEPERATION(SEP),
        .H1_SHIFT(H1)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .data_in(data_in),
        .data_in_valid(data_in_valid),
        .signal_out(signal_out),
        .signal_out_valid(signal_out_valid)
    );

    always #5 clk = ~clk;

    typedef struct { int due; int val; } exp_t;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t pend[$];
    int   got[$];
    int   last_out = 0;

    // model state
    int   m_phase = 0;
    int   m_b1 = 0;
    int   m_hist = 0;
    int   gray_tab [4] = '{0, 1, 3, 2};  // index b1*2+b0 -> symbol

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clamp(input int v);
        int hi, lo;
        hi = (1 << (R - 1)) - 1;
        lo = -(1 << (R - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic int floor_div_pow2(input int v, input int sh);
        int d;
        d = 1 << sh;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    // Behavioural model: evaluated on each rising edge from the inputs presented to it
    always @(posedge clk) begin
        int sym, lvl, y;
        exp_t e;
        cyc++;
        if (!rstn) begin
            m_phase = 0;
            m_hist  = 0;
            pend.delete();
            last_out = 0;
        end else if (data_in_valid) begin
            if (m_phase == 0) begin
                m_b1    = int'(data_in);
                m_phase = 1;
            end else begin
                m_phase = 0;
                sym = gray_tab[m_b1 * 2 + int'(data_in)];
                lvl = clamp(((2 * sym - 3) * SEP) / 2);
                y   = ISI ? clamp(lvl + floor_div_pow2(m_hist, H1)) : lvl;
                m_hist = lvl;
                e.due = cyc + 2;
                e.val = y;
                pend.push_back(e);
            end
        end
    end

    // Per-cycle comparison on the falling edge
    always @(negedge clk) begin
        int act, e;
        bit exp_v;
        if (cyc > 0) begin
            act   = int'($signed(signal_out));
            exp_v = (pend.size() > 0) && (pend[0].due == cyc);
            chk("valid", int'(signal_out_valid), int'(exp_v));
            if (exp_v) begin
                e = pend.pop_front().val;
                last_out = e;
                chk("level", act, e);
                got.push_back(act);
            end else begin
                chk("hold", act, last_out);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            data_in_valid = 1'b0;
            data_in = 1'b0;
        end
    endtask

    task automatic send(input logic b);
        @(negedge clk);
        data_in = b;
        data_in_valid = 1'b1;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rstn = 1'b0;
        data_in_valid = 1'b0;
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            data_in = (i % 2 == 1);
            data_in_valid = 1'b1;  // bits during reset must be ignored
        end
        @(negedge clk);
        rstn = 1'b1;
        data_in_valid = 1'b0;
    endtask

    initial begin
        // Reset held 3 cycles, then idle: nothing may come out
        do_reset(3);
        chk("rst_out", int'(signal_out), 0);
        chk("rst_valid", int'(signal_out_valid), 0);
        got.delete();
        idle(4);
        chk("idle_pulses", got.size(), 0);

        // 0,0 -> -84
        got.delete();
        send(1'b0); send(1'b0); idle(5);
        chk("p00_count", got.size(), 1);
        if (got.size() >= 1) chk("p00_val", got[0], -84);

        // 1,0,1,0 back-to-back
        do_reset(2); got.delete();
        send(1'b1); send(1'b0); send(1'b1); send(1'b0); idle(5);
        chk("p1010_count", got.size(), 2);
        if (got.size() >= 2) begin
            chk("p1010_a", got[0], 84);
            chk("p1010_b", got[1], ISI ? 126 : 84);
        end

        // 0,1,1,1
        do_reset(2); got.delete();
        send(1'b0); send(1'b1); send(1'b1); send(1'b1); idle(5);
        chk("p0111_count", got.size(), 2);
        if (got.size() >= 2) begin
            chk("p0111_a", got[0], -28);
            chk("p0111_b", got[1], ISI ? 14 : 28);
        end

        // 1, five invalid cycles, 1 -> +28
        do_reset(2); got.delete();
        send(1'b1); idle(5);
        chk("gap_no_pulse", got.size(), 0);
        send(1'b1); idle(5);
        chk("gap_count", got.size(), 1);
        if (got.size() >= 1) chk("gap_val", got[0], 28);

        // Partial pair then reset, then 1,1 -> single +28
        do_reset(2);
        send(1'b0); send(1'b1); send(1'b1); idle(1);  // leaves history and a pending first bit
        do_reset(2); got.delete();
        send(1'b1); send(1'b1); idle(5);
        chk("partial_count", got.size(), 1);
        if (got.size() >= 1) chk("partial_val", got[0], 28);

        // Reset landing mid-pipeline kills the in-flight symbol
        do_reset(2);
        send(1'b1); send(1'b0);
        do_reset(1); got.delete(); idle(5);
        chk("midpipe_count", got.size(), 0);
        chk("midpipe_out", int'(signal_out), 0);

        // Longer mixed stream exercised against the model only
        do_reset(2);
        for (int i = 0; i < 40; i++) begin
            if (i % 7 == 3) idle(1);
            send(logic'((i * 5 + i / 3) % 2));
        end
        idle(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
